hls_deadlock_report_collector: RTL and testbench
================================================

// Module: hls_deadlock_report_collector
// PURPOSE
//  Top-level consumer of the per-instance deadlock monitor "block" flags.
//  Filters the raw flags: a deadlock is confirmed only after some flag has been
//  high for CONFIRM_CYCLES consecutive cycles. On confirmation it latches which
//  monitors were blocked, then emits one report record per blocked monitor over
//  a valid/ready stream to the debug/trace sink. The block halts until cleared.
// PARAMETERS
//  NUM_MON         8     number of monitor block inputs
//  IDX_W           3     report index width; must be >= clog2(NUM_MON)
//  CONFIRM_CYCLES  1024  consecutive blocked cycles required; must be >= 1
//  CNT_W           11    watch counter width; must hold CONFIRM_CYCLES
//  TS_W            32    timestamp width
// PORTS
//  clock          in   1        clock
//  reset          in   1        synchronous, active-high reset
//  monitor_block  in   NUM_MON  raw block flags, one per monitor
//  clear          in   1        synchronous re-arm pulse
//  deadlock_flag  out  1        confirmed deadlock, sticky until clear/reset
//  report_valid   out  1        report record valid
//  report_ready   in   1        sink accepts record
//  report_idx     out  IDX_W    index of the blocked monitor in this record
//  report_last    out  1        final record of this deadlock
//  report_cycle   out  TS_W     timestamp at confirmation (same in all records)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; watch_cnt, mask and timestamp = 0.
//  - Priority: reset > clear > normal operation.
//  - Timestamp: free-running, +1 per cycle, saturates at all-ones.
//    Cleared only by reset, never by clear.
//  - any_blk = |monitor_block.
//  - States: IDLE, WATCH, REPORT, HALT.
//  - IDLE: if any_blk, go to WATCH with watch_cnt = 1.
//  - WATCH: if !any_blk, go to IDLE with watch_cnt = 0.
//    Otherwise watch_cnt increments.
//  - Confirm edge: the edge that samples the CONFIRM_CYCLES-th consecutive
//    cycle with any_blk = 1. With CONFIRM_CYCLES = 1 this is the first blocked
//    sample, taken directly from IDLE.
//  - At the confirm edge:
//    - mask <= monitor_block (nonzero by construction);
//    - report_cycle <= timestamp;
//    - deadlock_flag <= 1;
//    - state <= REPORT;
//    - report_valid <= 1.
//  - Bit pattern changes during WATCH do not restart the count while any_blk
//    stays high. Only the pattern at the confirm edge is captured.
//  - REPORT:
//    - report_idx = lowest set bit of mask.
//    - report_last = 1 iff exactly one mask bit is set.
//    - report_valid, report_idx, report_last and report_cycle stay stable
//      while report_ready = 0.
//    - On a valid & ready edge, that mask bit is cleared.
//    - If bits remain, valid stays high and the next index is presented the
//      following cycle. One record per cycle under constant ready.
//    - If no bits remain, valid <= 0 and state <= HALT.
//  - HALT: deadlock_flag held at 1; no further records; monitor_block ignored.
//  - monitor_block is ignored in REPORT and HALT. Registering later deadlocks
//    requires clear.
//  - clear in any state, next edge: state IDLE, watch_cnt 0, mask 0,
//    deadlock_flag 0, report_valid 0.
//    - Any in-flight record is dropped.
//    - Detection restarts from count 0 on the following cycle; blocked cycles
//      seen during the clear edge do not count.
//  - Outputs are all registered. Flag and first record appear on the same edge.
// TESTING (CONFIRM_CYCLES=4, NUM_MON=8)
//  1. monitor_block=0x04 for 3 cycles, then 0 -> flag stays 0; state returns
//     IDLE; a later 4-cycle block still confirms.
//  2. monitor_block=0x22 steady, ready=1 -> flag=1 after the 4th blocked edge;
//     records idx=1 last=0, then idx=5 last=1 on consecutive cycles; valid=0
//     after; HALT.
//  3. As 2 with ready=0 for 10 cycles -> valid=1, idx=1, cycle held stable;
//     releasing ready completes both records.
//  4. Alternate 0x01 / 0x80 each cycle -> confirms after 4 edges;
//     mask = pattern at the confirm edge; one record emitted.
//  5. clear mid-REPORT (after first record) -> next cycle flag=0, valid=0;
//     re-blocking needs 4 fresh cycles; the new report_cycle is larger.
//  6. reset asserted in WATCH at watch_cnt=2 -> all outputs 0; a new block
//     needs 4 full cycles; timestamp restarts at 0.

Source files
------------

// File: rtl/hls_deadlock_report_collector.sv
// Confirms a deadlock once any monitor block flag stays high for CONFIRM_CYCLES
// cycles, latches the blocked set, and streams one report record per blocked monitor.
module hls_deadlock_report_collector #(
    parameter int NUM_MON        = 8,
    parameter int IDX_W          = 3,
    parameter int CONFIRM_CYCLES = 1024,
    parameter int CNT_W          = 11,
    parameter int TS_W           = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] monitor_block,
    input  logic               clear,
    output logic               deadlock_flag,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic               report_last,
    output logic [TS_W-1:0]    report_cycle
);

    typedef enum logic [1:0] {IDLE, WATCH, REPORT, HALT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   watch_cnt_q;
    logic [NUM_MON-1:0] mask_q;
    logic [TS_W-1:0]    ts_q;
    logic               flag_q;
    logic               valid_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;
    logic [TS_W-1:0]    cycle_q;

    logic               any_blk;
    logic               confirm;
    logic [NUM_MON-1:0] mask_pop_d;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [NUM_MON-1:0] v);
        return (v != '0) && ((v & (v - NUM_MON'(1))) == '0);
    endfunction

    assign any_blk    = |monitor_block;
    // Dropping the lowest set bit retires the record currently on the bus.
    assign mask_pop_d = mask_q & (mask_q - NUM_MON'(1));

    // The confirm edge samples the CONFIRM_CYCLES-th consecutive blocked cycle.
    assign confirm = any_blk &&
                     (((state_q == IDLE)  && (CONFIRM_CYCLES == 1)) ||
                      ((state_q == WATCH) && (watch_cnt_q == CNT_W'(CONFIRM_CYCLES - 1))));

    // NOTE: every state register here uses non-blocking assignment so all of them
    // update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            watch_cnt_q <= '0;
            mask_q      <= '0;
            ts_q        <= '0;
            flag_q      <= 1'b0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            cycle_q     <= '0;
        end else begin
            if (ts_q != '1) ts_q <= ts_q + TS_W'(1);

            if (clear) begin
                state_q     <= IDLE;
                watch_cnt_q <= '0;
                mask_q      <= '0;
                flag_q      <= 1'b0;
                valid_q     <= 1'b0;
                idx_q       <= '0;
                last_q      <= 1'b0;
            end else if (confirm) begin
                state_q     <= REPORT;
                watch_cnt_q <= '0;
                mask_q      <= monitor_block;
                cycle_q     <= ts_q;
                flag_q      <= 1'b1;
                valid_q     <= 1'b1;
                idx_q       <= lowest_set(monitor_block);
                last_q      <= is_onehot(monitor_block);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_blk) begin
                            state_q     <= WATCH;
                            watch_cnt_q <= CNT_W'(1);
                        end
                    end
                    WATCH: begin
                        if (!any_blk) begin
                            state_q     <= IDLE;
                            watch_cnt_q <= '0;
                        end else begin
                            watch_cnt_q <= watch_cnt_q + CNT_W'(1);
                        end
                    end
                    REPORT: begin
                        if (report_ready) begin
                            mask_q <= mask_pop_d;
                            idx_q  <= lowest_set(mask_pop_d);
                            last_q <= is_onehot(mask_pop_d);
                            if (mask_pop_d == '0) begin
                                valid_q <= 1'b0;
                                state_q <= HALT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign deadlock_flag = flag_q;
    assign report_valid  = valid_q;
    assign report_idx    = idx_q;
    assign report_last   = last_q;
    assign report_cycle  = cycle_q;

endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// Directed bench for hls_deadlock_report_collector with CONFIRM_CYCLES=4, NUM_MON=8.
module tb_hls_deadlock_report_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  monitor_block;
    logic        clear;
    logic        deadlock_flag;
    logic        report_valid;
    logic        report_ready;
    logic [2:0]  report_idx;
    logic        report_last;
    logic [31:0] report_cycle;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] t_conf;
    logic [31:0] first_cycle;

    hls_deadlock_report_collector #(
        .NUM_MON(8), .IDX_W(3), .CONFIRM_CYCLES(4), .CNT_W(11), .TS_W(32)
    ) dut (
        .clock(clock), .reset(reset), .monitor_block(monitor_block), .clear(clear),
        .deadlock_flag(deadlock_flag), .report_valid(report_valid),
        .report_ready(report_ready), .report_idx(report_idx),
        .report_last(report_last), .report_cycle(report_cycle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later. cyc tracks the DUT timestamp.
    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) cyc++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_flag", 32'(deadlock_flag), 0);
        check("clear_valid", 32'(report_valid), 0);
    endtask

    // Drives pattern for 4 edges; confirms on the 4th. Records expected timestamp.
    task automatic block4(input logic [7:0] pat, input string tag);
        monitor_block = pat;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_pre_flag"}, 32'(deadlock_flag), 0);
        end
        t_conf = 32'(cyc);
        tick();
        check({tag, "_flag"}, 32'(deadlock_flag), 1);
        check({tag, "_valid"}, 32'(report_valid), 1);
        check({tag, "_cycle"}, report_cycle, t_conf);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; monitor_block = '0; report_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        cyc = 0;
        check("rst_flag", 32'(deadlock_flag), 0);
        check("rst_valid", 32'(report_valid), 0);
        check("rst_idx", 32'(report_idx), 0);
        check("rst_last", 32'(report_last), 0);
        check("rst_cycle", report_cycle, 0);

        // 1: three blocked cycles then release, no confirmation
        monitor_block = 8'h04;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_short_flag", 32'(deadlock_flag), 0);
        end
        monitor_block = 8'h00;
        tick();
        check("t1_release_flag", 32'(deadlock_flag), 0);
        tick();
        check("t1_idle_valid", 32'(report_valid), 0);
        block4(8'h04, "t1");
        check("t1_idx", 32'(report_idx), 2);
        check("t1_last", 32'(report_last), 1);
        report_ready = 1'b1;
        tick();
        check("t1_done_valid", 32'(report_valid), 0);
        check("t1_halt_flag", 32'(deadlock_flag), 1);
        tick(); tick();
        check("t1_halt_valid", 32'(report_valid), 0);
        check("t1_halt_flag2", 32'(deadlock_flag), 1);

        // 2: two monitors, ready held high
        report_ready = 1'b1;
        monitor_block = 8'h00;
        do_clear();
        block4(8'h22, "t2");
        check("t2_idx0", 32'(report_idx), 1);
        check("t2_last0", 32'(report_last), 0);
        tick();
        check("t2_valid1", 32'(report_valid), 1);
        check("t2_idx1", 32'(report_idx), 5);
        check("t2_last1", 32'(report_last), 1);
        tick();
        check("t2_done_valid", 32'(report_valid), 0);
        check("t2_halt_flag", 32'(deadlock_flag), 1);
        tick();
        check("t2_halt_valid", 32'(report_valid), 0);

        // 3: backpressure holds the first record stable
        report_ready = 1'b0;
        monitor_block = 8'h00;
        do_clear();
        block4(8'h22, "t3");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", 32'(report_valid), 1);
            check("t3_hold_idx", 32'(report_idx), 1);
            check("t3_hold_cycle", report_cycle, t_conf);
        end
        report_ready = 1'b1;
        tick();
        check("t3_idx1", 32'(report_idx), 5);
        check("t3_last1", 32'(report_last), 1);
        check("t3_cycle1", report_cycle, t_conf);
        tick();
        check("t3_done_valid", 32'(report_valid), 0);

        // 4: alternating patterns; only the confirm-edge pattern is captured
        monitor_block = 8'h00;
        do_clear();
        report_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            monitor_block = (i % 2 == 0) ? 8'h01 : 8'h80;
            tick();
            check("t4_flag", 32'(deadlock_flag), (i == 3) ? 1 : 0);
        end
        check("t4_idx", 32'(report_idx), 7);
        check("t4_last", 32'(report_last), 1);
        report_ready = 1'b1;
        tick();
        check("t4_done_valid", 32'(report_valid), 0);

        // 5: clear mid-report, re-detection needs four fresh cycles
        monitor_block = 8'h00;
        do_clear();
        report_ready = 1'b1;
        block4(8'h22, "t5a");
        first_cycle = report_cycle;
        tick();
        check("t5_second_idx", 32'(report_idx), 5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clr_flag", 32'(deadlock_flag), 0);
        check("t5_clr_valid", 32'(report_valid), 0);
        block4(8'h22, "t5b");
        check("t5_later_cycle", 32'(report_cycle > first_cycle), 1);

        // 6: reset while in WATCH at count 2
        monitor_block = 8'h00;
        do_clear();
        monitor_block = 8'h10;
        tick(); tick();
        check("t6_watch_flag", 32'(deadlock_flag), 0);
        reset = 1'b1;
        tick();
        check("t6_rst_flag", 32'(deadlock_flag), 0);
        check("t6_rst_valid", 32'(report_valid), 0);
        check("t6_rst_idx", 32'(report_idx), 0);
        check("t6_rst_last", 32'(report_last), 0);
        check("t6_rst_cycle", report_cycle, 0);
        reset = 1'b0;
        cyc = 0;
        block4(8'h10, "t6");
        check("t6_cycle_abs", report_cycle, 3);
        check("t6_idx", 32'(report_idx), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
